// File: rtl/instruction_fetch_controller.sv
// Instruction fetch front end: one outstanding memory request feeding a
// 2-entry in-order instruction queue, with branch redirect and response drop.
module instruction_fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_stall,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        DROP
    } state_t;

    localparam logic [31:0] START_PC = RESET_PC & ~32'd3;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic        run_q, run_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] qpc_q [2];
    logic [31:0] qpc_d [2];
    logic [31:0] qinstr_q [2];
    logic [31:0] qinstr_d [2];

    logic        consume;
    logic        accept;
    logic        push;
    logic [1:0]  count_after;
    logic [31:0] target_pc;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= FETCH;
            pc_q    <= START_PC;
            addr_q  <= START_PC;
            run_q   <= 1'b0;
            count_q <= 2'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            run_q   <= run_d;
            count_q <= count_d;
        end
    end

    // NOTE: queue payload carries no reset; it is only observed through
    // if_valid, which comes from the reset occupancy count.
    always_ff @(posedge clk) begin
        qpc_q    <= qpc_d;
        qinstr_q <= qinstr_d;
    end

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    // NOTE: every variable gets a default at the top of an always_comb so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        run_d    = 1'b1;
        count_d  = count_q;
        qpc_d    = qpc_q;
        qinstr_d = qinstr_q;

        target_pc   = redirect_pc & ~32'd3;
        consume     = (count_q != 2'd0) && !id_stall && !redirect_valid;
        accept      = imem_req && imem_ready;
        push        = accept && (state_q != DROP) && !redirect_valid;
        count_after = count_q - {1'b0, consume};

        unique case (state_q)
            FETCH: begin
                if (imem_req && !imem_ready) begin
                    state_d = redirect_valid ? DROP : WAIT;
                    addr_d  = pc_q;
                end
            end
            WAIT: begin
                if (imem_ready) begin
                    state_d = FETCH;
                end else if (redirect_valid) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_ready) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase

        // While dropping, pc_q already holds the redirect target.
        if (redirect_valid) begin
            pc_d = target_pc;
        end else if (accept && (state_q != DROP)) begin
            pc_d = imem_addr + 32'd4;
        end

        if (redirect_valid) begin
            count_d = 2'd0;
        end else begin
            if (consume) begin
                qpc_d[0]    = qpc_q[1];
                qinstr_d[0] = qinstr_q[1];
            end
            if (push) begin
                qpc_d[count_after[0]]    = imem_addr;
                qinstr_d[count_after[0]] = imem_rdata;
            end
            count_d = count_after + {1'b0, push};
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        unique case (state_q)
            FETCH: begin
                // Issue only if the word will have a queue slot after this cycle's pop.
                imem_req  = run_q &&
                            ((count_q - {1'b0, (count_q != 2'd0) && !id_stall}) < 2'd2);
                imem_addr = pc_q;
            end
            default: begin
                imem_req  = 1'b1;
                imem_addr = addr_q;
            end
        endcase

        if_valid = (count_q != 2'd0);
        if_pc    = if_valid ? qpc_q[0] : 32'd0;
        if_instr = if_valid ? qinstr_q[0] : 32'd0;
    end

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Bench for instruction_fetch_controller: a memory responder with per-request
// latency and a scoreboard of program-order instructions expected at decode.
module tb_instruction_fetch_controller;

    localparam logic [31:0] RESET_PC_TB = 32'h0000_0000;
    localparam logic [31:0] NO_SLOW     = 32'h0000_0001;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        id_stall = 1'b0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    always #5 clk = ~clk;

    instruction_fetch_controller #(
        .RESET_PC(RESET_PC_TB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_stall      (id_stall),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_instr      (if_instr)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      exp_q[$];
    int          n_cmp = 0;
    int          n_mis = 0;
    int          n_consumed = 0;
    logic [31:0] fetch_exp_pc = RESET_PC_TB;
    logic [31:0] prev_addr = 32'd0;
    logic [31:0] slow_addr = NO_SLOW;
    int          slow_lat = 0;
    int          wait_cnt = 0;
    int          cur_lat = 0;
    bit          rand_lat = 1'b0;
    bit          drop_pending = 1'b0;
    bit          prev_pending = 1'b0;
    bit          prev_redirect = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hC0DE_5A5A;
    endfunction

    // One clock cycle: drive inputs at negedge, answer the request, check
    // the decode-side view against the scoreboard, then update the model.
    task automatic step(input bit stall, input bit redir, input logic [31:0] rpc,
                        input bit rst_low);
        entry_t head;
        bit     accepted;
        @(negedge clk);
        reset          = ~rst_low;
        id_stall       = stall;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_ready     = 1'b0;
        imem_rdata     = 32'hDEAD_BEEF;
        #1;
        if (rst_low) begin
            exp_q.delete();
            fetch_exp_pc  = RESET_PC_TB;
            drop_pending  = 1'b0;
            prev_pending  = 1'b0;
            prev_redirect = 1'b0;
            return;
        end
        if (prev_pending) begin
            n_cmp++;
            if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
                n_mis++;
                $display("FAIL req_hold: req=%b addr=%h, required req=1 addr=%h",
                         imem_req, imem_addr, prev_addr);
            end
        end
        if (prev_redirect) begin
            n_cmp++;
            if (if_valid !== 1'b0) begin
                n_mis++;
                $display("FAIL flush: if_valid=%b, required 0", if_valid);
            end
        end
        if (imem_req === 1'b1) begin
            if (!prev_pending) begin
                wait_cnt = 0;
                cur_lat  = (imem_addr == slow_addr) ? slow_lat :
                           (rand_lat ? int'($urandom_range(0, 2)) : 0);
            end else begin
                wait_cnt++;
            end
            if (wait_cnt >= cur_lat) begin
                imem_ready = 1'b1;
                imem_rdata = mem_word(imem_addr);
            end
        end
        #1;
        n_cmp++;
        if (if_valid !== (exp_q.size() != 0)) begin
            n_mis++;
            $display("FAIL if_valid: got %b, required %b", if_valid, exp_q.size() != 0);
        end
        if (exp_q.size() != 0) begin
            head = exp_q[0];
            n_cmp++;
            if (if_pc !== head.pc || if_instr !== head.instr) begin
                n_mis++;
                $display("FAIL head: if_pc=%h if_instr=%h, required %h %h",
                         if_pc, if_instr, head.pc, head.instr);
            end
        end
        if (exp_q.size() == 2 && stall) begin
            n_cmp++;
            if (imem_req !== 1'b0) begin
                n_mis++;
                $display("FAIL issue_when_full: imem_req=%b, required 0", imem_req);
            end
        end

        accepted = (imem_req === 1'b1) && imem_ready;
        if (if_valid === 1'b1 && !stall && !redir) begin
            n_consumed++;
            if (exp_q.size() != 0) head = exp_q.pop_front();
        end
        if (redir) begin
            if (accepted) drop_pending = 1'b0;
            else if (imem_req === 1'b1) drop_pending = 1'b1;
            exp_q.delete();
            fetch_exp_pc = rpc & ~32'd3;
        end else if (accepted) begin
            if (drop_pending) begin
                drop_pending = 1'b0;
            end else begin
                n_cmp++;
                if (imem_addr !== fetch_exp_pc) begin
                    n_mis++;
                    $display("FAIL fetch_order: addr=%h, required %h", imem_addr, fetch_exp_pc);
                end
                exp_q.push_back({fetch_exp_pc, mem_word(fetch_exp_pc)});
                fetch_exp_pc = fetch_exp_pc + 32'd4;
            end
        end
        n_cmp++;
        if (exp_q.size() > 2) begin
            n_mis++;
            $display("FAIL queue_depth: %0d words fetched ahead, required at most 2", exp_q.size());
            head = exp_q.pop_back();
        end
        prev_pending  = (imem_req === 1'b1) && !imem_ready;
        prev_addr     = imem_addr;
        prev_redirect = redir;
    endtask

    task automatic reset_dut();
        slow_addr = NO_SLOW;
        rand_lat  = 1'b0;
        step(1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b0);
        n_cmp++;
        if (if_valid !== 1'b0 || if_pc !== 32'd0 || if_instr !== 32'd0) begin
            n_mis++;
            $display("FAIL reset_if: valid=%b pc=%h instr=%h, required 0 0 0", if_valid, if_pc, if_instr);
        end
        n_cmp++;
        if (imem_req !== 1'b0 || imem_addr !== RESET_PC_TB) begin
            n_mis++;
            $display("FAIL reset_imem: req=%b addr=%h, required 0 %h", imem_req, imem_addr, RESET_PC_TB);
        end
        step(1'b0, 1'b0, 32'd0, 1'b0);
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC_TB) begin
            n_mis++;
            $display("FAIL first_req: req=%b addr=%h, required 1 %h", imem_req, imem_addr, RESET_PC_TB);
        end
    endtask

    task automatic test_zero_wait();
        reset_dut();
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b0, 32'd0, 1'b0);
            n_cmp++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin
                n_mis++;
                $display("FAIL stream_addr[%0d]: req=%b addr=%h, required 1 %h", k, imem_req, imem_addr, 32'(4 * k));
            end
            n_cmp++;
            if (k == 0) begin
                if (if_valid !== 1'b0) begin
                    n_mis++;
                    $display("FAIL stream_if[0]: if_valid=%b, required 0", if_valid);
                end
            end else if (if_valid !== 1'b1 || if_pc !== 32'(4 * (k - 1))) begin
                n_mis++;
                $display("FAIL stream_if[%0d]: valid=%b pc=%h, required 1 %h", k, if_valid, if_pc, 32'(4 * (k - 1)));
            end
        end
        n_consumed = 0;
        for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 32'd0, 1'b0);
        n_cmp++;
        if (n_consumed != 20) begin
            n_mis++;
            $display("FAIL throughput: %0d consumed in 20 cycles, required 20", n_consumed);
        end
    endtask

    task automatic test_slow_mem();
        int held = 0;
        bit saw_next = 1'b0;
        reset_dut();
        slow_addr = 32'd8;
        slow_lat  = 3;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b0, 32'd0, 1'b0);
            if (imem_req === 1'b1 && imem_addr == 32'd8) held++;
            if (imem_req === 1'b1 && imem_addr == 32'd12) begin
                saw_next = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (held != 4 || !saw_next) begin
            n_mis++;
            $display("FAIL slow_hold: addr 8 held %0d cycles (next seen=%b), required 4 (1)", held, saw_next);
        end
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 32'd0, 1'b0);
        slow_addr = NO_SLOW;
    endtask

    task automatic test_stall();
        reset_dut();
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'd0, 1'b0);
        for (int s = 0; s < 5; s++) begin
            step(1'b1, 1'b0, 32'd0, 1'b0);
            n_cmp++;
            if (if_valid !== 1'b1 || if_pc !== 32'd8) begin
                n_mis++;
                $display("FAIL stall_head[%0d]: valid=%b pc=%h, required 1 %h", s, if_valid, if_pc, 32'd8);
            end
            if (s == 4) begin
                n_cmp++;
                if (imem_req !== 1'b0) begin
                    n_mis++;
                    $display("FAIL stall_full_req: imem_req=%b, required 0", imem_req);
                end
            end
        end
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic test_redirect_drop();
        bit found = 1'b0;
        bit moved = 1'b0;
        reset_dut();
        slow_addr = 32'd16;
        slow_lat  = 6;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b0, 32'd0, 1'b0);
            if (imem_req === 1'b1 && imem_addr == 32'd16) begin
                found = 1'b1;
                break;
            end
        end
        step(1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b1, 32'h0000_0103, 1'b0);
        n_cmp++;
        if (!found || imem_req !== 1'b1 || imem_addr !== 32'd16 || imem_ready !== 1'b0) begin
            n_mis++;
            $display("FAIL drop_setup: found=%b req=%b addr=%h ready=%b, required 1 1 %h 0",
                     found, imem_req, imem_addr, imem_ready, 32'd16);
        end
        slow_addr = NO_SLOW;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b0, 32'd0, 1'b0);
            if (imem_req === 1'b1 && imem_addr != 32'd16) begin
                moved = 1'b1;
                break;
            end
            n_cmp++;
            if (if_valid !== 1'b0) begin
                n_mis++;
                $display("FAIL drop_if_valid: if_valid=%b while dropping, required 0", if_valid);
            end
        end
        n_cmp++;
        if (!moved || imem_addr !== 32'h0000_0100) begin
            n_mis++;
            $display("FAIL drop_target: moved=%b addr=%h, required 1 %h", moved, imem_addr, 32'h0000_0100);
        end
        step(1'b0, 1'b0, 32'd0, 1'b0);
        n_cmp++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0000_0100) begin
            n_mis++;
            $display("FAIL drop_first: valid=%b pc=%h, required 1 %h", if_valid, if_pc, 32'h0000_0100);
        end
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic test_redirect_ready();
        reset_dut();
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b1, 32'h0000_2000, 1'b0);
        n_cmp++;
        if (imem_req !== 1'b1 || imem_ready !== 1'b1 || if_valid !== 1'b1) begin
            n_mis++;
            $display("FAIL rr_setup: req=%b ready=%b if_valid=%b, required 1 1 1", imem_req, imem_ready, if_valid);
        end
        step(1'b0, 1'b0, 32'd0, 1'b0);
        n_cmp++;
        if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_2000) begin
            n_mis++;
            $display("FAIL rr_after: valid=%b req=%b addr=%h, required 0 1 %h",
                     if_valid, imem_req, imem_addr, 32'h0000_2000);
        end
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic test_wrap();
        logic [31:0] exp_addr [4];
        int n = 0;
        exp_addr[0] = 32'hFFFF_FFF8;
        exp_addr[1] = 32'hFFFF_FFFC;
        exp_addr[2] = 32'h0000_0000;
        exp_addr[3] = 32'h0000_0004;
        reset_dut();
        step(1'b0, 1'b1, 32'hFFFF_FFFA, 1'b0);
        for (int k = 0; k < 10 && n < 4; k++) begin
            step(1'b0, 1'b0, 32'd0, 1'b0);
            if (imem_req === 1'b1 && imem_ready === 1'b1) begin
                n_cmp++;
                if (imem_addr !== exp_addr[n]) begin
                    n_mis++;
                    $display("FAIL wrap[%0d]: addr=%h, required %h", n, imem_addr, exp_addr[n]);
                end
                n++;
            end
        end
        n_cmp++;
        if (n != 4) begin
            n_mis++;
            $display("FAIL wrap_count: %0d fetches seen, required 4", n);
        end
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic test_reset_in_wait();
        bit found = 1'b0;
        reset_dut();
        slow_addr = 32'd8;
        slow_lat  = 20;
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0, 32'd0, 1'b0);
            if (imem_req === 1'b1 && imem_addr == 32'd8) begin
                found = 1'b1;
                break;
            end
        end
        step(1'b0, 1'b0, 32'd0, 1'b0);
        n_cmp++;
        if (!found || imem_req !== 1'b1 || imem_addr !== 32'd8) begin
            n_mis++;
            $display("FAIL rw_setup: found=%b req=%b addr=%h, required 1 1 %h", found, imem_req, imem_addr, 32'd8);
        end
        step(1'b0, 1'b0, 32'd0, 1'b1);
        slow_addr = NO_SLOW;
        step(1'b0, 1'b0, 32'd0, 1'b0);
        n_cmp++;
        if (if_valid !== 1'b0 || if_pc !== 32'd0 || if_instr !== 32'd0 ||
            imem_req !== 1'b0 || imem_addr !== RESET_PC_TB) begin
            n_mis++;
            $display("FAIL rw_reset: valid=%b pc=%h instr=%h req=%b addr=%h, required 0 0 0 0 %h",
                     if_valid, if_pc, if_instr, imem_req, imem_addr, RESET_PC_TB);
        end
        step(1'b0, 1'b0, 32'd0, 1'b0);
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC_TB) begin
            n_mis++;
            $display("FAIL rw_restart: req=%b addr=%h, required 1 %h", imem_req, imem_addr, RESET_PC_TB);
        end
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic test_back_to_back();
        reset_dut();
        rand_lat   = 1'b1;
        n_consumed = 0;
        for (int k = 0; k < 300; k++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0,
                 $urandom & 32'h0000_0FFF, 1'b0);
        end
        rand_lat = 1'b0;
        n_cmp++;
        if (n_consumed < 30) begin
            n_mis++;
            $display("FAIL random_progress: %0d consumed in 300 cycles, required at least 30", n_consumed);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_zero_wait();
        test_slow_mem();
        test_stall();
        test_redirect_drop();
        test_redirect_ready();
        test_wrap();
        test_reset_in_wait();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
